// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
// serializer_pkg : shared FSM state type and CRC defaults for serializer_crc
// Rev 1.0
// ============================================================================
package serializer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_CRC_POLY = 32'h07;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serializer_crc_if.sv
`default_nettype none
// ============================================================================
// serializer_crc_if : parallel-word input and serial-bit output bundle
// Rev 1.0
// ============================================================================
interface serializer_crc_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             d_valid;
    logic             d_ready;
    logic             out;
    logic             out_valid;
    logic             last;

    modport master (output din, d_valid, input d_ready, out, out_valid, last);
    modport slave  (input din, d_valid, output d_ready, out, out_valid, last);
endinterface
`default_nettype wire

// File: rtl/crc_lfsr.sv
`default_nettype none
// ============================================================================
// crc_lfsr : bit-serial CRC register, init 0, no reflection, no final XOR
// Rev 1.0
// ============================================================================
module crc_lfsr
    import serializer_pkg::*;
#(
    parameter int                   CRC_WIDTH = 8,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY  = CRC_WIDTH'(DEFAULT_CRC_POLY)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 bit_in,
    output logic [CRC_WIDTH-1:0] crc
);
    logic fb;

    assign fb = crc[CRC_WIDTH-1] ^ bit_in;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
    end
endmodule
`default_nettype wire

// File: rtl/serializer_crc.sv
`default_nettype none
// ============================================================================
// serializer_crc : parallel-to-serial framer; define CRC_APPEND_EN to append
//                  a CRC_WIDTH-bit CRC (MSB first) after each data word.
// Rev 1.0
// ============================================================================
module serializer_crc
    import serializer_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int          MSB_FIRST = 1,
    parameter int          CRC_WIDTH = 8,
    parameter int unsigned CRC_POLY  = DEFAULT_CRC_POLY
) (
    input  logic             clk,
    input  logic             rst,
    serializer_crc_if.slave  bus
);
    localparam int CNT_W = $clog2(max2(WIDTH, CRC_WIDTH));

    generate
        if (WIDTH < 2 || WIDTH > 64 || CRC_WIDTH < 4 || CRC_WIDTH > 32 ||
            (CRC_POLY >> CRC_WIDTH) != 0) begin : g_bad_params
            $error("serializer_crc: parameter out of range");
        end
    endgenerate

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_sh, din_w;
    logic [CNT_W-1:0] cnt;
    logic             data_bit, data_end, last_w, ready, accept, out_bit;

    assign din_w = bus.din;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign data_bit = shreg[WIDTH-1];
            assign shreg_sh = {shreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign data_bit = shreg[0];
            assign shreg_sh = {1'b0, shreg[WIDTH-1:1]};
        end
    endgenerate

    assign data_end = (state == DATA) && (cnt == CNT_W'(WIDTH - 1));

`ifdef CRC_APPEND_EN
    localparam logic [CRC_WIDTH-1:0] POLY = CRC_POLY[CRC_WIDTH-1:0];
    localparam logic [CRC_WIDTH-1:0] TOP  = {1'b1, {(CRC_WIDTH-1){1'b0}}};

    logic [CRC_WIDTH-1:0] crc;
    logic                 crc_bit;

    // CRC is frozen during the CRC phase; the counter walks a mask down from the MSB.
    crc_lfsr #(
        .CRC_WIDTH (CRC_WIDTH),
        .CRC_POLY  (POLY)
    ) u_crc_lfsr (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (state == DATA),
        .bit_in (data_bit),
        .crc    (crc)
    );

    assign crc_bit = |(crc & (TOP >> cnt));
    assign last_w  = (state == CRC) && (cnt == CNT_W'(CRC_WIDTH - 1));
`else
    assign last_w  = data_end;
`endif

    // Ready during the final bit lets the next frame follow with no idle cycle.
    assign ready  = (state == IDLE) || last_w;
    assign accept = bus.d_valid && ready;

    assign bus.d_ready   = ready;
    assign bus.out_valid = (state != IDLE);
    assign bus.last      = last_w;
    assign bus.out       = out_bit;

    always_comb begin
        state_nxt = state;
        out_bit   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = DATA;
            end
            DATA: begin
                out_bit = data_bit;
                if (data_end) begin
`ifdef CRC_APPEND_EN
                    state_nxt = CRC;
`else
                    state_nxt = accept ? DATA : IDLE;
`endif
                end
            end
`ifdef CRC_APPEND_EN
            CRC: begin
                out_bit = crc_bit;
                if (last_w) state_nxt = accept ? DATA : IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                shreg <= din_w;
                cnt   <= '0;
            end else if (state != IDLE) begin
                if (state == DATA) shreg <= shreg_sh;
                cnt <= (state_nxt != state) ? '0 : cnt + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_serializer_crc.sv
`default_nettype none
// ============================================================================
// tb_serializer_crc : MSB-first and LSB-first instances driven in lockstep,
//                     checked every cycle against a queue-of-frame-bits model.
// Rev 1.0
// ============================================================================
module tb_serializer_crc;
    localparam int WIDTH     = 8;
    localparam int CRC_WIDTH = 8;
    localparam logic [CRC_WIDTH-1:0] POLY = 8'h07;
`ifdef CRC_APPEND_EN
    localparam int FRAME = WIDTH + CRC_WIDTH;
`else
    localparam int FRAME = WIDTH;
`endif

    typedef bit bitq_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serializer_crc_if #(.WIDTH(WIDTH)) bus_m ();
    serializer_crc_if #(.WIDTH(WIDTH)) bus_l ();
    assign bus_l.din     = bus_m.din;
    assign bus_l.d_valid = bus_m.d_valid;

    serializer_crc #(.WIDTH(WIDTH), .MSB_FIRST(1), .CRC_WIDTH(CRC_WIDTH), .CRC_POLY(32'h07))
        dut_m (.clk(clk), .rst(rst), .bus(bus_m));
    serializer_crc #(.WIDTH(WIDTH), .MSB_FIRST(0), .CRC_WIDTH(CRC_WIDTH), .CRC_POLY(32'h07))
        dut_l (.clk(clk), .rst(rst), .bus(bus_l));

    logic [7:0] obs;
    assign obs = {bus_m.out, bus_m.out_valid, bus_m.last, bus_m.d_ready,
                  bus_l.out, bus_l.out_valid, bus_l.last, bus_l.d_ready};

    bitq_t exp_m, exp_l;
    int    errors = 0;
    int    checks = 0;

    // Whole frame as the list of bits that should appear on out, in order.
    function automatic bitq_t frame_bits(input logic [WIDTH-1:0] w, input bit msb);
        bitq_t q;
        logic [CRC_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) q.push_back(msb ? w[WIDTH-1-i] : w[i]);
`ifdef CRC_APPEND_EN
        foreach (q[i]) begin
            bit fb;
            fb = c[CRC_WIDTH-1] ^ q[i];
            c  = (c << 1) ^ (fb ? POLY : '0);
        end
        for (int i = CRC_WIDTH - 1; i >= 0; i--) q.push_back(c[i]);
`endif
        return q;
    endfunction

    function automatic logic [3:0] pick(input bitq_t q);
        return {(q.size() > 0) ? q[0] : 1'b0, q.size() > 0, q.size() == 1, q.size() <= 1};
    endfunction

    function automatic logic [7:0] exp_vec();
        return {pick(exp_m), pick(exp_l)};
    endfunction

    task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit r);
        bus_m.d_valid = v;
        bus_m.din     = d;
        rst           = r;
    endtask

    task automatic advance(output bit acc);
        bit               r;
        logic [WIDTH-1:0] d;
        r   = rst;
        d   = bus_m.din;
        acc = !r && bus_m.d_valid && (exp_m.size() <= 1);
        @(posedge clk);
        if (r) begin
            exp_m.delete();
            exp_l.delete();
        end else begin
            if (exp_m.size() > 0) void'(exp_m.pop_front());
            if (exp_l.size() > 0) void'(exp_l.pop_front());
            if (acc) begin
                exp_m = frame_bits(d, 1'b1);
                exp_l = frame_bits(d, 1'b0);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit acc;
        drive(1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) advance(acc);
        checks++;
        if (obs !== 8'b0001_0001) begin
            errors++;
            $display("FAIL reset_outputs obs=%b exp=%b", obs, 8'b0001_0001);
        end
        drive(1'b0, 8'h00, 1'b0);
        advance(acc);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle obs=%b exp=%b", obs, exp_vec());
        end
    endtask

    task automatic test_directed_da();
        bit acc;
        logic [31:0] got_m, got_l;
        int n;
        got_m = '0; got_l = '0; n = 0;
        drive(1'b1, 8'hDA, 1'b0);
        for (int cyc = 0; cyc < FRAME + 4; cyc++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL directed_da cyc=%0d obs=%b exp=%b", cyc, obs, exp_vec());
            end
            if (bus_m.out_valid === 1'b1) begin
                got_m = {got_m[30:0], bus_m.out};
                got_l = {got_l[30:0], bus_l.out};
                n++;
            end
            advance(acc);
            drive(1'b0, 8'($urandom), 1'b0);
        end
        checks++;
        if (n != FRAME) begin
            errors++;
            $display("FAIL da_frame_len got=%0d exp=%0d", n, FRAME);
        end
        checks++;
        if (got_m[FRAME-1 -: 8] !== 8'hDA) begin
            errors++;
            $display("FAIL da_msb_bits got=%h exp=%h", got_m[FRAME-1 -: 8], 8'hDA);
        end
        checks++;
        if (got_l[FRAME-1 -: 8] !== 8'h5B) begin
            errors++;
            $display("FAIL da_lsb_bits got=%h exp=%h", got_l[FRAME-1 -: 8], 8'h5B);
        end
`ifdef CRC_APPEND_EN
        checks++;
        if (got_m[7:0] !== 8'h08) begin
            errors++;
            $display("FAIL da_crc got=%h exp=%h", got_m[7:0], 8'h08);
        end
`endif
    endtask

    task automatic test_back_to_back();
        bit acc, last_at_second;
        int n_acc, run, max_run;
        n_acc = 0; run = 0; max_run = 0; last_at_second = 1'b0;
        drive(1'b1, 8'hDA, 1'b0);
        for (int cyc = 0; cyc < 3 * FRAME; cyc++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d obs=%b exp=%b", cyc, obs, exp_vec());
            end
            run = (bus_m.out_valid === 1'b1) ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (bus_m.d_valid && n_acc == 1 && bus_m.d_ready === 1'b1) last_at_second = bus_m.last;
            advance(acc);
            if (acc) n_acc++;
            if (n_acc == 1) drive(1'b1, 8'h3C, 1'b0);
            else if (n_acc >= 2) drive(1'b0, 8'h00, 1'b0);
        end
        checks++;
        if (max_run != 2 * FRAME) begin
            errors++;
            $display("FAIL b2b_contiguous got=%0d exp=%0d", max_run, 2 * FRAME);
        end
        checks++;
        if (last_at_second !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept_in_last got=%b exp=1", last_at_second);
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        logic [31:0] got_m;
        got_m = '0;
        drive(1'b1, 8'hFF, 1'b0);
        advance(acc);
        drive(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) advance(acc);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL rst_mid_bit4 obs=%b exp=%b", obs, exp_vec());
        end
        drive(1'b1, 8'h55, 1'b1);
        advance(acc);
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (obs !== 8'b0001_0001) begin
            errors++;
            $display("FAIL rst_mid_abort obs=%b exp=%b", obs, 8'b0001_0001);
        end
        drive(1'b1, 8'h81, 1'b0);
        for (int cyc = 0; cyc < FRAME + 3; cyc++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL rst_mid_next cyc=%0d obs=%b exp=%b", cyc, obs, exp_vec());
            end
            if (bus_m.out_valid === 1'b1) got_m = {got_m[30:0], bus_m.out};
            advance(acc);
            drive(1'b0, 8'h00, 1'b0);
        end
        checks++;
        if (got_m[FRAME-1 -: 8] !== 8'h81) begin
            errors++;
            $display("FAIL rst_mid_81 got=%h exp=%h", got_m[FRAME-1 -: 8], 8'h81);
        end
    endtask

    task automatic test_ignore();
        bit acc;
        int n;
        n = 0;
        drive(1'b1, 8'h3C, 1'b0);
        for (int cyc = 0; cyc < 2 * FRAME + 2; cyc++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL ignore cyc=%0d obs=%b exp=%b", cyc, obs, exp_vec());
            end
            if (bus_m.out_valid === 1'b1) n++;
            advance(acc);
            drive(cyc == 3, 8'h00, 1'b0);
        end
        checks++;
        if (n != FRAME) begin
            errors++;
            $display("FAIL ignore_no_extra got=%0d exp=%0d", n, FRAME);
        end
    endtask

    task automatic test_random();
        bit acc;
        for (int cyc = 0; cyc < 400; cyc++) begin
            drive($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 40) == 0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d obs=%b exp=%b", cyc, obs, exp_vec());
            end
            advance(acc);
        end
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        test_reset();
        test_directed_da();
        test_back_to_back();
        test_reset_mid();
        test_ignore();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/serializer_crc.md
SERIALIZER_CRC -- requirements
Module: serializer_crc

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the parallel word width in bits (range 2..64).
REQ-002 The module SHALL have parameter MSB_FIRST, default 1, where 1 sends din[WIDTH-1] first and 0 sends din[0] first.
REQ-003 The module SHALL have parameter CRC_WIDTH, default 8, meaning the CRC register width (range 4..32).
REQ-004 The module SHALL have parameter CRC_POLY, default 8'h07, meaning the generator polynomial without its implicit top bit.
REQ-005 The module SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 din  input  WIDTH  parallel data word.
REQ-009 d_valid  input  1  din is valid this cycle.
REQ-010 d_ready  output  1  block can accept a word this cycle.
REQ-011 out  output  1  serial bit.
REQ-012 out_valid  output  1  out carries a frame bit this cycle.
REQ-013 last  output  1  out carries the final bit of the frame.

Function
REQ-014 A word SHALL be accepted on a rising clk edge where d_valid && d_ready; din is ignored at all other times.
REQ-015 The FSM SHALL have states IDLE, DATA and CRC; CRC exists only when CRC_APPEND_EN is defined.
- IDLE -> DATA on accept.
- DATA -> CRC after bit WIDTH-1 when the macro is defined.
- DATA -> IDLE after bit WIDTH-1 when the macro is undefined.
- CRC -> IDLE after bit CRC_WIDTH-1.
REQ-016 d_ready SHALL be 1 in IDLE and during the cycle in which last=1, and 0 otherwise.
REQ-017 The first data bit SHALL appear on out with out_valid=1 in the cycle after accept, so latency is 1 cycle.
REQ-018 Data bits SHALL be emitted one per cycle for exactly WIDTH consecutive cycles, with no gaps.
REQ-019 A bit counter of width clog2(max(WIDTH,CRC_WIDTH)) SHALL index bits and SHALL reset to 0 on each state entry.
REQ-020 An accept in the last=1 cycle SHALL load the new word and start its DATA phase in the next cycle, so back-to-back frames have zero idle cycles.
REQ-021 If there is no accept in the last=1 cycle, the block SHALL enter IDLE with out_valid=0 and out=0.
REQ-022 In IDLE, out SHALL be 0 and out_valid and last SHALL be 0.
REQ-023 The CRC SHALL be computed serially over the data bits in transmitted order, with init 0 and no reflection or final XOR.
- fb = crc[CRC_WIDTH-1] ^ bit.
- crc = (crc << 1) ^ (fb ? CRC_POLY : 0).
REQ-024 The CRC register SHALL clear to 0 on every accept.
REQ-025 d_valid asserted while d_ready=0 SHALL have no effect, and the word is not latched.

Reset
REQ-026 When rst=1 at a clk edge, the state SHALL become IDLE, the shift register, counter and CRC SHALL clear to 0, and outputs SHALL be d_ready=1, out=0, out_valid=0, last=0 from the next cycle.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, with no further bits emitted.
REQ-028 rst SHALL take priority over an accept in the same cycle.

Configuration
REQ-029 With CRC_APPEND_EN defined, the CRC SHALL be sent MSB first after the data for CRC_WIDTH cycles, and last SHALL be set on the final CRC bit, giving a frame of WIDTH+CRC_WIDTH bits.
REQ-030 With CRC_APPEND_EN undefined, the block SHALL contain no CRC logic, and last SHALL be set on data bit WIDTH-1, giving a frame of WIDTH bits.

Structure
REQ-031 The state enum (IDLE/DATA/CRC) and the default CRC_POLY constant SHALL reside in the shared package serializer_pkg.
REQ-032 The CRC update SHALL be the sub-module crc_lfsr, with inputs clk, rst, clr, en and bit, and output crc.

Verification
REQ-033 WIDTH=8, MSB_FIRST=1, macro undefined, din=8'hDA with a one-cycle d_valid SHALL produce out 1,1,0,1,1,0,1,0 on cycles 1..8, with last only on cycle 8, then IDLE.
REQ-034 The same stimulus with MSB_FIRST=0 SHALL produce out 0,1,0,1,1,0,1,1.
REQ-035 With CRC_APPEND_EN defined, MSB_FIRST=1 and din=8'hDA, the block SHALL send the 8 data bits followed by CRC 8'h08 (0,0,0,0,1,0,0,0), with last on bit 16.
REQ-036 With macro undefined, d_valid held high with words 8'hDA then 8'h3C SHALL produce 16 contiguous out_valid cycles, with the second word accepted in the last=1 cycle.
REQ-037 rst pulsed on data bit 4 of 8'hFF SHALL give out_valid=0 on the next cycle, d_ready=1, and a following 8'h81 serialized correctly with a fresh CRC.
REQ-038 A d_valid pulse with 8'h00 during DATA SHALL be ignored, leaving the current frame unaltered and no extra frame.
